// File: rtl/prf_free_list_pkg.sv
// Shared types and defaults for the physical-register free list.
// Default build sizes the PRF at 48 entries over a 32-entry ARF.
package prf_free_list_pkg;

    localparam int PRF_SIZE_DEF = 48;
    localparam int ARF_SIZE_DEF = 32;
    localparam int IDX_W_DEF    = $clog2(PRF_SIZE_DEF);

    typedef logic [IDX_W_DEF-1:0] prf_idx_t;

    typedef enum logic {
        ENC_LO = 1'b0,
        ENC_HI = 1'b1
    } enc_dir_e;

endpackage

// File: rtl/prf_pri_enc.sv
// Parameterized priority encoder, searching for the lowest or the
// highest set bit depending on the direction select.
module prf_pri_enc
    import prf_free_list_pkg::*;
#(
    parameter int N = 48,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  enc_dir_e     dir,
    output logic [W-1:0] idx,
    output logic         found
);

    // Ascending scan: first hit wins for LO, last hit wins for HI
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i] && (dir == ENC_HI || !found)) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prf_free_list.sv
// Free list of physical registers for the 2-way rename stage.
// Optional macro PRF_FREE_CNT_EN adds a registered free_count output.
module prf_free_list
    import prf_free_list_pkg::*;
#(
    parameter int PRF_SIZE = PRF_SIZE_DEF,
    parameter int ARF_SIZE = ARF_SIZE_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          request1,
    input  logic                          request2,
    output logic                          PRF_rename_valid1,
    output logic [$clog2(PRF_SIZE)-1:0]   PRF_rename_idx1,
    output logic                          PRF_rename_valid2,
    output logic [$clog2(PRF_SIZE)-1:0]   PRF_rename_idx2,
    input  logic                          commit_free_valid1,
    input  logic [$clog2(PRF_SIZE)-1:0]   commit_free_idx1,
    input  logic                          commit_free_valid2,
    input  logic [$clog2(PRF_SIZE)-1:0]   commit_free_idx2,
    input  logic                          PRF_free_valid,
    input  logic [PRF_SIZE-1:0]           PRF_free_list_in,
`ifdef PRF_FREE_CNT_EN
    output logic [$clog2(PRF_SIZE+1)-1:0] free_count,
`endif
    output logic                          free_list_empty,
    output logic                          free_list_almost_empty
);

    localparam int IDX_W = $clog2(PRF_SIZE);
    localparam int CNT_W = $clog2(PRF_SIZE + 1);

    // Architectural mappings own the low entries out of reset
    localparam logic [PRF_SIZE-1:0] RESET_BITS =
        {{(PRF_SIZE-ARF_SIZE){1'b1}}, {ARF_SIZE{1'b0}}};

    logic [PRF_SIZE-1:0] free_bits;
    logic [PRF_SIZE-1:0] next_bits;
    logic [IDX_W-1:0]    lo;
    logic [IDX_W-1:0]    hi;
    logic                found_lo;
    logic                found_hi;
    logic                multi;
    logic                avail;
    logic                valid1;
    logic                valid2;

    prf_pri_enc #(.N(PRF_SIZE), .W(IDX_W)) u_enc_lo (
        .vec   (free_bits),
        .dir   (ENC_LO),
        .idx   (lo),
        .found (found_lo)
    );

    prf_pri_enc #(.N(PRF_SIZE), .W(IDX_W)) u_enc_hi (
        .vec   (free_bits),
        .dir   (ENC_HI),
        .idx   (hi),
        .found (found_hi)
    );

    // Zero-latency grants; slot1 wins when only one entry is free
    always_comb begin
        multi  = found_lo & found_hi & (lo != hi);
        avail  = reset & found_lo & ~PRF_free_valid;
        valid1 = avail & request1;
        valid2 = avail & request2 & (multi | ~request1);
        PRF_rename_valid1 = valid1;
        PRF_rename_valid2 = valid2;
        PRF_rename_idx1   = valid1 ? lo : '0;
        PRF_rename_idx2   = valid2 ? (request1 ? hi : lo) : '0;
    end

    // Next bitmap: clear grants, then apply commit and recovery frees
    always_comb begin
        next_bits = free_bits;
        if (valid1)
            next_bits[lo] = 1'b0;
        if (valid2)
            next_bits[PRF_rename_idx2] = 1'b0;
        if (commit_free_valid1 && int'(commit_free_idx1) < PRF_SIZE)
            next_bits[commit_free_idx1] = 1'b1;
        if (commit_free_valid2 && int'(commit_free_idx2) < PRF_SIZE)
            next_bits[commit_free_idx2] = 1'b1;
        if (PRF_free_valid)
            next_bits = next_bits | PRF_free_list_in;
    end

    // Bitmap register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            free_bits <= RESET_BITS;
        else
            free_bits <= next_bits;
    end

`ifdef PRF_FREE_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] pop_next;

    // Population count of the bitmap being loaded
    always_comb begin
        pop_next = '0;
        for (int i = 0; i < PRF_SIZE; i++)
            pop_next = pop_next + CNT_W'(next_bits[i]);
    end

    // Counter tracks the bitmap edge for edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt_q <= CNT_W'(PRF_SIZE - ARF_SIZE);
        else
            cnt_q <= pop_next;
    end

    // Status from the registered counter
    always_comb begin
        free_count             = cnt_q;
        free_list_empty        = (cnt_q == '0);
        free_list_almost_empty = (cnt_q < CNT_W'(2));
    end
`else
    logic [CNT_W-1:0] pop_cur;

    // Status from a popcount of the registered bitmap
    always_comb begin
        pop_cur = '0;
        for (int i = 0; i < PRF_SIZE; i++)
            pop_cur = pop_cur + CNT_W'(free_bits[i]);
        free_list_empty        = (free_bits == '0);
        free_list_almost_empty = (pop_cur < CNT_W'(2));
    end
`endif

endmodule

// File: tb/tb_prf_free_list.sv
// Directed self-checking bench for prf_free_list.
// Stimulus changes on the falling edge; outputs sampled 1ns later.
module tb_prf_free_list;

    localparam int N = 48;

    logic          clock;
    logic          reset;
    logic          request1;
    logic          request2;
    logic          v1;
    logic [5:0]    i1;
    logic          v2;
    logic [5:0]    i2;
    logic          cv1;
    logic [5:0]    ci1;
    logic          cv2;
    logic [5:0]    ci2;
    logic          fv;
    logic [N-1:0]  fvec;
    logic          empty;
    logic          almost;
`ifdef PRF_FREE_CNT_EN
    logic [5:0]    fcnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    prf_free_list dut (
        .clock                  (clock),
        .reset                  (reset),
        .request1               (request1),
        .request2               (request2),
        .PRF_rename_valid1      (v1),
        .PRF_rename_idx1        (i1),
        .PRF_rename_valid2      (v2),
        .PRF_rename_idx2        (i2),
        .commit_free_valid1     (cv1),
        .commit_free_idx1       (ci1),
        .commit_free_valid2     (cv2),
        .commit_free_idx2       (ci2),
        .PRF_free_valid         (fv),
        .PRF_free_list_in       (fvec),
`ifdef PRF_FREE_CNT_EN
        .free_count             (fcnt),
`endif
        .free_list_empty        (empty),
        .free_list_almost_empty (almost)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_inputs;
        request1 = 1'b0;
        request2 = 1'b0;
        cv1 = 1'b0;
        ci1 = '0;
        cv2 = 1'b0;
        ci2 = '0;
        fv = 1'b0;
        fvec = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b0;
        request1 = 1'b1;
        request2 = 1'b1;
        #1;
        total_cnt++;
        if ({v1, i1, v2, i2} !== 14'd0)
            $display("FAIL reset_grants got v1=%0b i1=%0d v2=%0b i2=%0d exp all 0",
                     v1, i1, v2, i2);
        else
            pass_cnt++;
        total_cnt++;
        if ({empty, almost} !== 2'b00)
            $display("FAIL reset_status got empty=%0b almost=%0b exp 0/0",
                     empty, almost);
        else
            pass_cnt++;
`ifdef PRF_FREE_CNT_EN
        total_cnt++;
        if (fcnt !== 6'd16)
            $display("FAIL reset_count got %0d exp 16", fcnt);
        else
            pass_cnt++;
`endif
        @(negedge clock);
        clear_inputs();
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_grant_pair;
        do_reset();
        request1 = 1'b1;
        request2 = 1'b1;
        #1;
        total_cnt++;
        if ({v1, i1, v2, i2} !== {1'b1, 6'd32, 1'b1, 6'd47})
            $display("FAIL pair_c1 got v1=%0b i1=%0d v2=%0b i2=%0d exp 1/32 1/47",
                     v1, i1, v2, i2);
        else
            pass_cnt++;
        total_cnt++;
        if (empty !== 1'b0)
            $display("FAIL pair_empty got %0b exp 0", empty);
        else
            pass_cnt++;
        @(negedge clock);
        #1;
        total_cnt++;
        if ({v1, i1, v2, i2} !== {1'b1, 6'd33, 1'b1, 6'd46})
            $display("FAIL pair_c2 got v1=%0b i1=%0d v2=%0b i2=%0d exp 1/33 1/46",
                     v1, i1, v2, i2);
        else
            pass_cnt++;
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic test_slot2_only;
        do_reset();
        request2 = 1'b1;
        #1;
        total_cnt++;
        if ({v1, i1, v2, i2} !== {1'b0, 6'd0, 1'b1, 6'd32})
            $display("FAIL slot2_only got v1=%0b i1=%0d v2=%0b i2=%0d exp 0/0 1/32",
                     v1, i1, v2, i2);
        else
            pass_cnt++;
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic test_drain;
        do_reset();
        request1 = 1'b1;
        request2 = 1'b1;
        repeat (7) @(negedge clock);
        #1;
        total_cnt++;
        if ({empty, almost} !== 2'b00 || {v1, i1, v2, i2} !== {1'b1, 6'd39, 1'b1, 6'd40})
            $display("FAIL drain_two got e=%0b a=%0b i1=%0d i2=%0d exp 0/0 39/40",
                     empty, almost, i1, i2);
        else
            pass_cnt++;
        request2 = 1'b0;
        @(negedge clock);
        request2 = 1'b1;
        #1;
        total_cnt++;
        if ({empty, almost} !== 2'b01)
            $display("FAIL drain_one_status got e=%0b a=%0b exp 0/1", empty, almost);
        else
            pass_cnt++;
        total_cnt++;
        if ({v1, i1, v2, i2} !== {1'b1, 6'd40, 1'b0, 6'd0})
            $display("FAIL drain_one got v1=%0b i1=%0d v2=%0b i2=%0d exp 1/40 0/0",
                     v1, i1, v2, i2);
        else
            pass_cnt++;
        @(negedge clock);
        #1;
        total_cnt++;
        if ({empty, almost} !== 2'b11 || {v1, i1, v2, i2} !== 14'd0)
            $display("FAIL drain_empty got e=%0b a=%0b v1=%0b v2=%0b exp 1/1 0/0",
                     empty, almost, v1, v2);
        else
            pass_cnt++;
    endtask

    task automatic test_commit;
        request1 = 1'b1;
        request2 = 1'b1;
        cv1 = 1'b1;
        ci1 = 6'd5;
        cv2 = 1'b1;
        ci2 = 6'd12;
        #1;
        total_cnt++;
        if ({v1, v2} !== 2'b00)
            $display("FAIL commit_nobypass got v1=%0b v2=%0b exp 0/0", v1, v2);
        else
            pass_cnt++;
        @(negedge clock);
        cv1 = 1'b0;
        cv2 = 1'b0;
        #1;
        total_cnt++;
        if ({v1, i1, v2, i2} !== {1'b1, 6'd5, 1'b1, 6'd12})
            $display("FAIL commit_grant got v1=%0b i1=%0d v2=%0b i2=%0d exp 1/5 1/12",
                     v1, i1, v2, i2);
        else
            pass_cnt++;
        @(negedge clock);
        clear_inputs();
        cv1 = 1'b1;
        ci1 = 6'd7;
        cv2 = 1'b1;
        ci2 = 6'd7;
        @(negedge clock);
        cv2 = 1'b0;
        ci1 = 6'd50;
        @(negedge clock);
        cv1 = 1'b0;
        request1 = 1'b1;
        request2 = 1'b1;
        #1;
        total_cnt++;
        if ({empty, almost} !== 2'b01)
            $display("FAIL commit_dup_status got e=%0b a=%0b exp 0/1", empty, almost);
        else
            pass_cnt++;
        total_cnt++;
        if ({v1, i1, v2, i2} !== {1'b1, 6'd7, 1'b0, 6'd0})
            $display("FAIL commit_dup got v1=%0b i1=%0d v2=%0b i2=%0d exp 1/7 0/0",
                     v1, i1, v2, i2);
        else
            pass_cnt++;
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic test_recovery;
        fv = 1'b1;
        fvec[10] = 1'b1;
        fvec[12] = 1'b1;
        request1 = 1'b1;
        #1;
        total_cnt++;
        if ({v1, i1} !== 7'd0)
            $display("FAIL recov_squash got v1=%0b i1=%0d exp 0/0", v1, i1);
        else
            pass_cnt++;
        @(negedge clock);
        fv = 1'b0;
        fvec = '0;
        request2 = 1'b1;
        #1;
        total_cnt++;
        if ({v1, i1, v2, i2} !== {1'b1, 6'd10, 1'b1, 6'd12})
            $display("FAIL recov_grant got v1=%0b i1=%0d v2=%0b i2=%0d exp 1/10 1/12",
                     v1, i1, v2, i2);
        else
            pass_cnt++;
        @(negedge clock);
        clear_inputs();
        fv = 1'b1;
        fvec[3] = 1'b1;
        cv1 = 1'b1;
        ci1 = 6'd9;
        @(negedge clock);
        clear_inputs();
        request1 = 1'b1;
        request2 = 1'b1;
        #1;
        total_cnt++;
        if ({v1, i1, v2, i2} !== {1'b1, 6'd3, 1'b1, 6'd9})
            $display("FAIL recov_commit got v1=%0b i1=%0d v2=%0b i2=%0d exp 1/3 1/9",
                     v1, i1, v2, i2);
        else
            pass_cnt++;
        @(negedge clock);
        clear_inputs();
        #1;
        total_cnt++;
        if ({empty, almost} !== 2'b11)
            $display("FAIL recov_empty got e=%0b a=%0b exp 1/1", empty, almost);
        else
            pass_cnt++;
    endtask

    task automatic test_async_reset;
        do_reset();
        request1 = 1'b1;
        request2 = 1'b1;
        @(negedge clock);
        #1;
        total_cnt++;
        if ({v1, i1, v2, i2} !== {1'b1, 6'd33, 1'b1, 6'd46})
            $display("FAIL areset_pre got v1=%0b i1=%0d v2=%0b i2=%0d exp 1/33 1/46",
                     v1, i1, v2, i2);
        else
            pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({v1, i1, v2, i2} !== 14'd0 || {empty, almost} !== 2'b00)
            $display("FAIL areset_now got v1=%0b i1=%0d v2=%0b i2=%0d e=%0b a=%0b exp 0",
                     v1, i1, v2, i2, empty, almost);
        else
            pass_cnt++;
`ifdef PRF_FREE_CNT_EN
        total_cnt++;
        if (fcnt !== 6'd16)
            $display("FAIL areset_count got %0d exp 16", fcnt);
        else
            pass_cnt++;
`endif
        @(negedge clock);
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({v1, i1, v2, i2} !== {1'b1, 6'd32, 1'b1, 6'd47})
            $display("FAIL areset_post got v1=%0b i1=%0d v2=%0b i2=%0d exp 1/32 1/47",
                     v1, i1, v2, i2);
        else
            pass_cnt++;
        @(negedge clock);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_grant_pair();
        test_slot2_only();
        test_drain();
        test_commit();
        test_recovery();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/prf_free_list.md
Name: prf_free_list

Overview:
- Physical-register free list feeding the 2-way rename stage.
- Each cycle, supplies up to two free PRF indices to the RAT in response to its rename requests.
- Reclaims entries released by commit (two retire slots) and by misprediction recovery, which delivers a bulk free vector.
- Holds one bitmap register, one bit per PRF entry; 1 = free.

Parameters:
- PRF_SIZE, 48, number of physical registers.
- ARF_SIZE, 32, number of architectural registers. Entries 0..ARF_SIZE-1 are held at reset as the initial architectural mappings.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- request1  in  1  RAT slot1 asks for a destination PRF.
- request2  in  1  RAT slot2 asks for a destination PRF.
- PRF_rename_valid1  out  1  slot1 grant.
- PRF_rename_idx1  out  $clog2(PRF_SIZE)  slot1 granted index.
- PRF_rename_valid2  out  1  slot2 grant.
- PRF_rename_idx2  out  $clog2(PRF_SIZE)  slot2 granted index.
- commit_free_valid1  in  1  retire slot1 releases an entry.
- commit_free_idx1  in  $clog2(PRF_SIZE)  index released by retire slot1.
- commit_free_valid2  in  1  retire slot2 releases an entry.
- commit_free_idx2  in  $clog2(PRF_SIZE)  index released by retire slot2.
- PRF_free_valid  in  1  misprediction recovery vector is valid.
- PRF_free_list_in  in  PRF_SIZE  bit i = 1 returns entry i to the free list.
- free_list_empty  out  1  no free entries.
- free_list_almost_empty  out  1  fewer than 2 free entries.

Behaviour:
- State: free_bits[PRF_SIZE-1:0].
  - Reset value: bits 0..ARF_SIZE-1 = 0; bits ARF_SIZE..PRF_SIZE-1 = 1.
  - Applied asynchronously on reset=0. Reset mid-operation discards all in-flight state.
- Grant logic is combinational from registered free_bits, with zero latency. The RAT samples grants in the same cycle it raises its requests.
  - lo = lowest-index free bit; hi = highest-index free bit.
  - PRF_rename_idx1 = lo.
  - PRF_rename_idx2 = hi if request1=1, else lo.
  - Free count >=2: valid1 = request1; valid2 = request2.
  - Free count ==1: valid1 = request1; valid2 = request2 & ~request1. Slot1 has priority.
  - Free count ==0: both valids = 0.
  - PRF_free_valid=1 forces both valids to 0, since recovery squashes the rename.
- Whenever a valid output is 0, its idx output is 0.
- Rising-edge update, in this order: next = free_bits & ~grant_mask, then | commit frees, then | (PRF_free_valid ? PRF_free_list_in : 0).
  - grant_mask has the bit of each granted idx set.
  - Frees take effect next cycle. An entry freed this cycle is not grantable this cycle (no bypass).
- Boundary cases:
  - Both commit slots release the same idx: single set, harmless.
  - Freeing an already-free entry: idempotent, no error.
  - Commit free of an index >= PRF_SIZE: ignored.
  - Commit and recovery frees in the same cycle: both are applied.
  - Grant and free can never collide, because granted entries are not free.
- Status outputs, from registered state:
  - free_list_empty = (free_bits==0).
  - free_list_almost_empty = (popcount<2).
- Reset value of all outputs: valids 0, idx 0, free_list_empty 0, free_list_almost_empty 0. These hold while PRF_SIZE-ARF_SIZE >= 2.

Optional Feature:
- Macro: PRF_FREE_CNT_EN.
- Defined: adds output free_count, width $clog2(PRF_SIZE+1).
  - Registered popcount, updated each edge alongside free_bits.
  - Reset value = PRF_SIZE-ARF_SIZE.
  - free_list_empty and free_list_almost_empty are derived from the counter.
- Undefined: no free_count port; status outputs come from combinational popcount of free_bits.
- Grant behaviour is identical in both builds.

Decomposition:
- Shared package: PRF_SIZE/ARF_SIZE defaults and typedef prf_idx_t = logic [$clog2(PRF_SIZE)-1:0].
- One sub-module: prf_pri_enc, a parameterized priority encoder.
  - Input vector and direction select; outputs index and found.
  - Instantiated twice, once for lo and once for hi.

Test Plan:
1. Reset, then request1=request2=1 for 2 cycles -> cycle1 grants 32/47, cycle2 grants 33/46, both valid. free_list_empty=0.
2. request1=0, request2=1 after reset -> valid1=0, idx1=0; valid2=1, idx2=32.
3. Drain to 1 free entry, then request both -> valid1=1 with the remaining idx, valid2=0. Next cycle free_list_empty=1 and both valids 0 under requests.
4. With the list empty, commit_free_valid1=1 idx 5 and commit_free_valid2=1 idx 12 -> same cycle no grant; next cycle request both -> idx1=5, idx2=12.
5. PRF_free_valid=1 with PRF_free_list_in bits 10 and 12 set, plus request1=1 -> valid1=0. Next cycle grants lo=10, hi=12.
6. Assert reset=0 asynchronously mid-cycle after allocations -> outputs reset immediately; after release, grants restart at 32/47.
